// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deserialises
// device-to-host frames, checks framing/parity, and folds E0/F0/E1 prefix
// bytes into single 11-bit key events {toggle, pressed, extended, code}.
module ps2_key_encoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 48000,
  parameter int TW      = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Reset synchroniser: assertion is immediate, release is aligned to clk_sys.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  // Shift ones into the reset synchroniser once reset_n is released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n_int = rst_sync_reg[1];

  // Input conditioning
  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_clk_reg;
  logic          filt_clk_d_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;
  logic          data_bit;

  // Two-flop synchronisers for both asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
      data_sync_reg <= {data_sync_reg[0], ps2_data_in};
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER equal samples.
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      filt_clk_reg   <= 1'b1;
      filt_clk_d_reg <= 1'b1;
      filt_cnt_reg   <= '0;
    end else begin
      filt_clk_d_reg <= filt_clk_reg;
      if (clk_sync_reg[1] == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER - 1)) begin
        filt_clk_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

  assign fall     = filt_clk_d_reg & ~filt_clk_reg;
  assign data_bit = data_sync_reg[1];

  // Deserialiser
  state_t        state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          byte_valid_reg, byte_valid_next;
  logic          frame_err_reg, frame_err_next;

  // Deserialiser state and timeout registers.
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      par_reg        <= 1'b0;
      tmo_reg        <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      par_reg        <= par_next;
      tmo_reg        <= tmo_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Frame sequencing on filtered falling edges, with a mid-frame watchdog.
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    par_next        = par_reg;
    tmo_next        = tmo_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    if (state_reg != S_IDLE && !fall) begin
      // No edge this cycle: run the watchdog; a stalled frame is dropped.
      if (tmo_reg == '0) begin
        state_next     = S_IDLE;
        frame_err_next = 1'b1;
      end else begin
        tmo_next = tmo_reg - TW'(1);
      end
    end else if (fall) begin
      tmo_next = TW'(TIMEOUT);
      case (state_reg)
        S_IDLE: begin
          // A high start bit is treated as noise and ignored.
          if (!data_bit) begin
            state_next   = S_DATA;
            bit_cnt_next = '0;
          end
        end
        S_DATA: begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        end
        S_PARITY: begin
          par_next   = data_bit;
          state_next = S_STOP;
        end
        S_STOP: begin
          if (data_bit && ((^shift_reg) ^ par_reg)) byte_valid_next = 1'b1;
          else                                       frame_err_next  = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Prefix folding and key event output
  logic        ext_reg;
  logic        rel_reg;
  logic [2:0]  skip_reg;
  logic [10:0] key_reg;
  logic        strobe_reg;

  // Accumulate E0/F0 prefixes, swallow the Pause sequence, emit events.
  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      ext_reg    <= 1'b0;
      rel_reg    <= 1'b0;
      skip_reg   <= '0;
      key_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (frame_err_reg) begin
        ext_reg  <= 1'b0;
        rel_reg  <= 1'b0;
        skip_reg <= '0;
      end else if (byte_valid_reg) begin
        if (skip_reg != '0) begin
          skip_reg <= skip_reg - 3'd1;
        end else if (shift_reg == 8'hE1) begin
          skip_reg <= 3'd7;
        end else if (shift_reg == 8'hE0) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          rel_reg <= 1'b1;
        end else begin
          key_reg    <= {~key_reg[10], ~rel_reg, ext_reg, shift_reg};
          strobe_reg <= 1'b1;
          ext_reg    <= 1'b0;
          rel_reg    <= 1'b0;
        end
      end
    end
  end

  assign ps2_key    = key_reg;
  assign key_strobe = strobe_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives PS/2 frames, scoreboards the
// expected key events and checks strobe/error pulse counts per step.
`timescale 1ns/1ps
module tb_ps2_key_encoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 480;
  localparam int TW      = 16;
  localparam int HALF    = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  int pass_cnt   = 0;
  int fail_cnt   = 0;
  int total_cnt  = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  logic [10:0] exp_q[$];
  logic        exp_toggle = 1'b0;
  logic [10:0] last_exp = '0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  // Device-side frame: data changes while clk is high, sampled on the fall.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = f[i];
      cycles(5);
      if (i == glitch_at) begin
        ps2_clk_in = 1'b0;
        cycles(3);
        ps2_clk_in = 1'b1;
        cycles(HALF - 8);
      end else begin
        cycles(HALF - 5);
      end
      ps2_clk_in = 1'b0;
      cycles(HALF);
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, -1);
  endtask

  task automatic expect_key(input logic ext, input logic pressed, input logic [7:0] code);
    exp_toggle = ~exp_toggle;
    last_exp   = {exp_toggle, pressed, ext, code};
    exp_q.push_back(last_exp);
  endtask

  task automatic settle(input string tag, input int s0, input int e0,
                        input int ds, input int de);
    cycles(30);
    @(negedge clk_sys);
    chk({tag, "_strobes"}, 32'(strobe_cnt - s0), 32'(ds));
    chk({tag, "_errs"},    32'(err_cnt - e0),    32'(de));
    chk({tag, "_pending"}, 32'(exp_q.size()),    32'd0);
  endtask

  // Scoreboard: every strobe pops and compares the oldest expected event.
  always @(negedge clk_sys) begin
    if (key_strobe) begin
      strobe_cnt++;
      if (exp_q.size() > 0) chk("key_event", 32'(ps2_key), 32'(exp_q.pop_front()));
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    int s0, e0;

    // Reset state
    cycles(5);
    @(negedge clk_sys);
    chk("rst_key", 32'(ps2_key), 32'd0);
    chk("rst_strobe", 32'(key_strobe), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    cycles(10);

    // Press space
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b0, 1'b1, 8'h29);
    send(8'h29);
    settle("space", s0, e0, 1, 0);
    chk("space_word", 32'(ps2_key), 32'h629);

    // Release right arrow: E0 F0 74
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b1, 1'b0, 8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    settle("rarrow", s0, e0, 1, 0);
    chk("rarrow_word", 32'(ps2_key), 32'h174);

    // Bad parity then good 0x1C
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 11, -1);
    settle("badpar", s0, e0, 0, 1);
    chk("badpar_hold", 32'(ps2_key), 32'(last_exp));
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b0, 1'b1, 8'h1C);
    send(8'h1C);
    settle("goodpar", s0, e0, 1, 0);

    // E0, long idle between frames, then 0x75
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b1, 1'b1, 8'h75);
    send(8'hE0);
    cycles(TIMEOUT + TIMEOUT / 5);
    send(8'h75);
    settle("idle_gap", s0, e0, 1, 0);

    // Stall after 4 data bits: no error before TIMEOUT, one error after
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b0, 5, -1);
    cycles(TIMEOUT - 100);
    chk("tmo_early", 32'(err_cnt - e0), 32'd0);
    cycles(200);
    chk("tmo_fired", 32'(err_cnt - e0), 32'd1);
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b0, 1'b1, 8'h1C);
    send(8'h1C);
    settle("after_tmo", s0, e0, 1, 0);

    // Pause sequence swallowed, then 0x16
    s0 = strobe_cnt; e0 = err_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    settle("pause", s0, e0, 0, 0);
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b0, 1'b1, 8'h16);
    send(8'h16);
    settle("after_pause", s0, e0, 1, 0);

    // Short clock glitch mid-frame
    s0 = strobe_cnt; e0 = err_cnt;
    expect_key(1'b0, 1'b1, 8'h2A);
    send_frame(8'h2A, 1'b0, 11, 5);
    settle("glitch", s0, e0, 1, 0);

    // Reset mid-frame
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 6, -1);
    reset_n = 1'b0;
    exp_toggle = 1'b0;
    cycles(3);
    @(negedge clk_sys);
    chk("midrst_key", 32'(ps2_key), 32'd0);
    chk("midrst_strobe", 32'(key_strobe), 32'd0);
    reset_n = 1'b1;
    cycles(10);
    expect_key(1'b0, 1'b1, 8'h33);
    send(8'h33);
    settle("after_rst", s0, e0, 1, 0);
    chk("after_rst_word", 32'(ps2_key), 32'h633);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
